// File: rtl/ifu_fetch_queue_if.sv
// Fetch unit bundle: redirect, memory request/response channel and the decode-side queue output.
interface ifu_fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [ILEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            out_err;
  logic            busy;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           mem_rsp_err, out_ready,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, out_err, busy
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           mem_rsp_err, out_ready,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, out_err, busy
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Sequential instruction fetch: one outstanding memory request at a time, responses
// buffered in a DEPTH-entry queue toward decode; redirect flushes, bus error halts.
module ifu_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  ifu_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, REQ_DRAIN, WAIT, DRAIN, HALT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } fq_ent_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] redir_pc;
  fq_ent_t         q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]  count;
  logic            enq, deq;

  assign redir_pc = bus.redirect_pc & ~XLEN'(3);
  assign deq      = (count != '0) && bus.out_ready;

  // Next state; redirect dominates every other event in the cycle.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    enq          = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_nxt = redir_pc;
      case (state)
        REQ, REQ_DRAIN: state_nxt = bus.mem_req_ready ? DRAIN : REQ_DRAIN;
        // A response arriving with the redirect retires the outstanding request,
        // so there is nothing left to drain.
        WAIT, DRAIN:    state_nxt = bus.mem_rsp_valid ? IDLE : DRAIN;
        default:        state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: if (count < FULL) state_nxt = REQ;
        REQ: if (bus.mem_req_ready) begin
          state_nxt    = WAIT;
          fetch_pc_nxt = fetch_pc + XLEN'(4);
        end
        REQ_DRAIN: if (bus.mem_req_ready) state_nxt = DRAIN;
        WAIT: if (bus.mem_rsp_valid) begin
          enq       = 1'b1;
          state_nxt = bus.mem_rsp_err ? HALT : IDLE;
        end
        DRAIN: if (bus.mem_rsp_valid) state_nxt = IDLE;
        HALT: state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (state == IDLE && state_nxt == REQ) req_addr <= fetch_pc;
    end
  end

  // Queue bookkeeping; a flush overrides any enqueue/dequeue in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= '{pc: req_addr, inst: bus.mem_rsp_data, err: bus.mem_rsp_err};
  end

  assign bus.mem_req_valid = (state == REQ) || (state == REQ_DRAIN);
  assign bus.mem_req_addr  = req_addr;
  assign bus.busy          = (state == REQ) || (state == REQ_DRAIN) ||
                             (state == WAIT) || (state == DRAIN);
  assign bus.out_valid     = (count != '0);
  assign bus.out_pc        = q[rd_ptr].pc;
  assign bus.out_inst      = q[rd_ptr].inst;
  assign bus.out_err       = q[rd_ptr].err;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: responses pushed to a scoreboard as they are driven,
// popped and compared when decode takes the queue head.
module tb_ifu_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t sb[$];

  ifu_fetch_queue_if #(.XLEN(32), .ILEN(32)) bus ();

  ifu_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h8000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs set before step() apply to the next rising edge; step() scores the
  // out handshake that edge will perform, then advances to the next falling edge.
  task automatic step();
    ent_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow: got out_pc %0h want no entry", bus.out_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_pc", {32'h0, bus.out_pc}, {32'h0, e.pc});
        chk("out_inst", {32'h0, bus.out_inst}, {32'h0, e.inst});
        chk("out_err", {63'h0, bus.out_err}, {63'h0, e.err});
      end
    end
    if (bus.redirect_valid === 1'b1) sb.delete();
    @(negedge clk);
  endtask

  task automatic serve(input logic [31:0] data, input bit err, input int lat,
                       input logic [31:0] exp_addr, input string tag);
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    total++;
    assert (n < 50) else begin
      bad++;
      $error("FAIL %s_timeout: got no request after %0d cycles want one", tag, n);
    end
    if (n >= 50) return;
    chk({tag, "_addr"}, {32'h0, bus.mem_req_addr}, {32'h0, exp_addr});
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    repeat (lat - 1) step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    bus.mem_rsp_err   = err;
    sb.push_back('{pc: exp_addr, inst: data, err: err});
    step();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    repeat (8) step();
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  int hi;

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.mem_rsp_err    = 1'b0;
    bus.out_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'h0, bus.mem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'd0);
    chk("rst_busy", {63'h0, bus.busy}, 64'd0);
    rst_n = 1'b1;

    // Basic stream and minimum latency.
    step();
    chk("t1_req_valid", {63'h0, bus.mem_req_valid}, 64'd1);
    chk("t1_addr0", {32'h0, bus.mem_req_addr}, 64'h8000_0000);
    chk("t1_busy", {63'h0, bus.busy}, 64'd1);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("t1_outv_c2", {63'h0, bus.out_valid}, 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0013;
    sb.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013, err: 1'b0});
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("t1_outv_c3", {63'h0, bus.out_valid}, 64'd1);
    serve(32'h0000_0013, 1'b0, 1, 32'h8000_0004, "t1_f1");
    serve(32'h0000_0013, 1'b0, 1, 32'h8000_0008, "t1_f2");
    drain("t1");

    // Backpressure from decode fills the queue and stalls fetch.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      serve(32'h100 + 32'(i), 1'b0, 1, 32'h8000_0000 + 32'(4 * i), "t2_fill");
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req_valid !== 1'b0) hi++;
      step();
    end
    chk("t2_stall_reqs", 64'(hi), 64'd0);
    chk("t2_head_pc", {32'h0, bus.out_pc}, 64'h8000_0000);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    serve(32'h0000_0113, 1'b0, 1, 32'h8000_0010, "t2_refill");
    drain("t2");

    // Request held through memory backpressure, 3-cycle response.
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {63'h0, bus.mem_req_valid}, 64'd1);
      chk("t3_hold_addr", {32'h0, bus.mem_req_addr}, 64'h8000_0000);
      step();
    end
    serve(32'h0000_0213, 1'b0, 3, 32'h8000_0000, "t3_hs");
    drain("t3");

    // Redirect in WAIT with two entries queued; late response must be discarded.
    do_reset();
    bus.out_ready = 1'b0;
    serve(32'h0000_0313, 1'b0, 1, 32'h8000_0000, "t4_q0");
    serve(32'h0000_0413, 1'b0, 1, 32'h8000_0004, "t4_q1");
    while (bus.mem_req_valid !== 1'b1) step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready  = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1002;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_flush_outv", {63'h0, bus.out_valid}, 64'd0);
    chk("t4_drain_busy", {63'h0, bus.busy}, 64'd1);
    chk("t4_drain_noreq", {63'h0, bus.mem_req_valid}, 64'd0);
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("t4_late_dropped", {63'h0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b1;
    serve(32'h0000_0513, 1'b0, 1, 32'h8000_1000, "t4_new");
    drain("t4");

    // Redirect coinciding with the response in WAIT: no drain phase.
    serve(32'h0000_0613, 1'b0, 1, 32'h8000_1004, "t5_pre");
    drain("t5_pre");
    while (bus.mem_req_valid !== 1'b1) step();
    chk("t5_req_addr", {32'h0, bus.mem_req_addr}, 64'h8000_1008);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_data   = 32'hBAD0_0013;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    step();
    bus.mem_rsp_valid  = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("t5_no_drain", {63'h0, bus.busy}, 64'd0);
    chk("t5_outv", {63'h0, bus.out_valid}, 64'd0);
    serve(32'h0000_0713, 1'b0, 1, 32'h8000_2000, "t5_new");
    drain("t5");

    // Bus error on the second fetch halts until redirect.
    do_reset();
    bus.out_ready = 1'b0;
    serve(32'h0000_0813, 1'b0, 1, 32'h8000_0000, "t6_f0");
    serve(32'h0000_0913, 1'b1, 1, 32'h8000_0004, "t6_err");
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req_valid !== 1'b0) hi++;
      step();
    end
    chk("t6_halt_reqs", 64'(hi), 64'd0);
    chk("t6_halt_busy", {63'h0, bus.busy}, 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk("t6_err_pc", {32'h0, bus.out_pc}, 64'h8000_0004);
    chk("t6_err_flag", {63'h0, bus.out_err}, 64'd1);
    step();
    repeat (4) step();
    chk("t6_still_halted", {63'h0, bus.mem_req_valid}, 64'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_3000;
    step();
    bus.redirect_valid = 1'b0;
    serve(32'h0000_0a13, 1'b0, 1, 32'h8000_3000, "t6_resume");
    drain("t6");

    // Asynchronous reset in the middle of WAIT with an entry queued.
    bus.out_ready = 1'b0;
    serve(32'h0000_0b13, 1'b0, 1, 32'h8000_3004, "t7_q0");
    while (bus.mem_req_valid !== 1'b1) step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("t7_pre_outv", {63'h0, bus.out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_outv", {63'h0, bus.out_valid}, 64'd0);
    chk("t7_async_busy", {63'h0, bus.busy}, 64'd0);
    chk("t7_async_reqv", {63'h0, bus.mem_req_valid}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("t7_restart_addr", {32'h0, bus.mem_req_addr}, 64'h8000_0000);
    serve(32'h0000_0c13, 1'b0, 1, 32'h8000_0000, "t7_restart");
    drain("t7");

    // Redirect while the request is stalled (REQ_DRAIN), then PC wrap.
    chk("t8_pending_addr", {32'h0, bus.mem_req_addr}, 64'h8000_0004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("t8_reqdrain_valid", {63'h0, bus.mem_req_valid}, 64'd1);
    chk("t8_reqdrain_addr", {32'h0, bus.mem_req_addr}, 64'h8000_0004);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_0013;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("t8_drop_outv", {63'h0, bus.out_valid}, 64'd0);
    serve(32'h0000_0d13, 1'b0, 1, 32'hFFFF_FFFC, "t8_top");
    serve(32'h0000_0e13, 1'b0, 1, 32'h0000_0000, "t8_wrap");
    drain("t8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
